// File: rtl/mult_arbiter.sv
// Shares one pipelined 4x4 multiplier among NREQ requesters, returning tagged products in order.
// Define MULT_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round robin.
module mult_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned LAT  = 3
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [3:0]          mul_a,
    output logic [3:0]          mul_b,
    input  logic [7:0]          mul_c,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic [7:0]          res_data,
    input  logic                drain,
    output logic                drained,
    output logic                busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDrained
    } state_e;

    state_e                r_state;
    logic                  r_drained;
    logic [IDW-1:0]        r_ptr;
    logic [LAT:0]          r_tag_vld;
    logic [LAT:0][IDW-1:0] r_tag_id;

    logic                  w_issue_ok;
    logic                  w_gnt;
    logic                  w_pipe_empty;
    logic [IDW-1:0]        w_gnt_idx;
    logic [3:0]            w_sel_a;
    logic [3:0]            w_sel_b;

    assign w_issue_ok   = ((r_state == StIdle) || (r_state == StRun)) && !drain;
    assign w_pipe_empty = ~|r_tag_vld;

    // Winner is the valid requester at the smallest rotated distance from the pointer.
    always_comb begin : arb
        int v_best;
        int v_dist;
        v_best    = int'(NREQ);
        v_dist    = 0;
        w_gnt_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            v_dist = i;
`else
            v_dist = (i + int'(NREQ) - int'(r_ptr)) % int'(NREQ);
`endif
            if (req_valid[i] && (v_dist < v_best)) begin
                v_best    = v_dist;
                w_gnt_idx = IDW'(i);
            end
        end
        w_gnt = w_issue_ok && (v_best < int'(NREQ));
    end

    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt && (w_gnt_idx == IDW'(i))) begin
                req_ready[i] = 1'b1;
                w_sel_a      = req_a[4*i +: 4];
                w_sel_b      = req_b[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state   <= StIdle;
            r_drained <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_drained <= 1'b0;
                    if (drain) begin
                        r_state <= StDrain;
                    end else if (|req_valid) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_drained <= 1'b0;
                    if (drain) begin
                        r_state <= StDrain;
                    end else if (!w_gnt && w_pipe_empty) begin
                        r_state <= StIdle;
                    end
                end
                StDrain: begin
                    r_drained <= w_pipe_empty;
                    if (w_pipe_empty) begin
                        r_state <= StDrained;
                    end
                end
                StDrained: begin
                    r_drained <= drain;
                    if (!drain) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_drained <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_ptr     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            r_ptr <= '0;
`else
            if (w_gnt) begin
                r_ptr <= IDW'((int'(w_gnt_idx) + 1) % int'(NREQ));
            end
`endif
            mul_a     <= w_gnt ? w_sel_a : 4'd0;
            mul_b     <= w_gnt ? w_sel_b : 4'd0;
            // Final tag stage lines up with the cycle the product appears on mul_c.
            r_tag_vld <= {r_tag_vld[LAT-1:0], w_gnt};
            r_tag_id  <= {r_tag_id[LAT-1:0], w_gnt_idx};
            res_valid <= r_tag_vld[LAT];
            if (r_tag_vld[LAT]) begin
                res_id   <= r_tag_id[LAT];
                res_data <= mul_c;
            end
        end
    end

    assign drained = r_drained;
    assign busy    = (r_state == StRun) || (r_state == StDrain) || !w_pipe_empty;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural LAT-cycle multiplier on mul_c.
module tb_mult_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned LAT  = 3;

    logic                clk1 = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_a;
    logic [4*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic [3:0]          mul_a;
    logic [3:0]          mul_b;
    logic [7:0]          mul_c;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [7:0]          res_data;
    logic                drain;
    logic                drained;
    logic                busy;

    mult_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) u_dut (
        .clk1      (clk1),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .drain     (drain),
        .drained   (drained),
        .busy      (busy)
    );

    initial forever #5 clk1 = ~clk1;

    logic [7:0] r_mp [LAT];
    always @(posedge clk1) begin
        r_mp[0] <= {4'b0, mul_a} * {4'b0, mul_b};
        for (int k = 1; k < int'(LAT); k++) r_mp[k] <= r_mp[k-1];
    end
    assign mul_c = r_mp[LAT-1];

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    typedef struct {
        int id;
        int data;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Handshakes push expected results; result strobes pop and compare.
    initial forever begin
        exp_t e;
        @(negedge clk1);
        if (rst) begin
            sb.delete();
        end else begin
            check_eq("ready_onehot0", 32'($onehot0(req_ready)), 1);
            check_eq("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check_eq("res_unexpected", 32'(res_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("res_id", 32'(res_id), e.id);
                    check_eq("res_data", 32'(res_data), e.data);
                    check_eq("res_latency", 32'(cyc - e.cyc), LAT + 2);
                end
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{i, int'(req_a[4*i +: 4]) * int'(req_b[4*i +: 4]), cyc});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        drain     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk1);
            n++;
        end
        check_eq("sb_empty", 32'(sb.size()), 0);
        tick();
        tick();
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_r;
        int         n_res;
        int         last_res;
        int         d_cyc;
        int         n;

        req_a = '0;
        req_b = '0;
        do_reset();

        // Reset values
        @(negedge clk1);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_mul_a", 32'(mul_a), 0);
        check_eq("rst_mul_b", 32'(mul_b), 0);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_res_id", 32'(res_id), 0);
        check_eq("rst_res_data", 32'(res_data), 0);
        check_eq("rst_drained", 32'(drained), 0);
        check_eq("rst_busy", 32'(busy), 0);
        tick();

        // Single request from requester 2
        set_op(2, 4'd7, 4'd9);
        req_valid = 4'b0100;
        @(negedge clk1);
        check_eq("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        @(negedge clk1);
        check_eq("single_mul_a", 32'(mul_a), 7);
        check_eq("single_mul_b", 32'(mul_b), 9);
        check_eq("single_busy", 32'(busy), 1);
        tick();
        wait_empty(20);

        // All requesters held: round robin 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd15);
        req_valid = 4'hf;
        for (int k = 0; k < 5; k++) begin
            exp_r = 4'b0001 << (k % 4);
            @(negedge clk1);
            check_eq("rr_ready", 32'(req_ready), 32'(exp_r));
            tick();
        end
        req_valid = '0;
        wait_empty(20);

        // Corner products, back-to-back single issues
        set_op(0, 4'd15, 4'd15);
        set_op(1, 4'd0, 4'd13);
        set_op(3, 4'd8, 4'd8);
        req_valid = 4'b0001;
        @(negedge clk1);
        check_eq("corner0_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0010;
        @(negedge clk1);
        check_eq("corner1_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1000;
        @(negedge clk1);
        check_eq("corner3_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        wait_empty(20);

        // Drain after three issues with all requesters still valid
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 4'(3 + i), 4'(11 - i));
        req_valid = 4'hf;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            tick();
        end
        drain    = 1'b1;
        n_res    = 0;
        last_res = -10;
        d_cyc    = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk1);
            check_eq("drain_blocks_grant", 32'(req_ready), 0);
            if (res_valid) begin
                n_res++;
                last_res = cyc;
            end
            if (drained && d_cyc < 0) d_cyc = cyc;
            tick();
        end
        check_eq("drain_res_count", 32'(n_res), 3);
        check_eq("drained_timing", 32'(d_cyc), 32'(last_res + 1));
        check_eq("drained_level", 32'(drained), 1);
        check_eq("drained_busy", 32'(busy), 0);
        drain = 1'b0;
        n     = 0;
        while (n < 5) begin
            @(negedge clk1);
            if (req_ready != '0) break;
            n++;
            tick();
        end
        check_eq("resume_grant", 32'(req_ready), 32'b1000);
        check_eq("resume_drained", 32'(drained), 0);
        tick();
        req_valid = '0;
        wait_empty(20);

        // Reset two cycles after two issues flushes everything
        do_reset();
        set_op(0, 4'd5, 4'd6);
        set_op(1, 4'd9, 4'd2);
        req_valid = 4'b0011;
        @(negedge clk1);
        check_eq("mid_ready0", 32'(req_ready), 32'b0001);
        tick();
        @(negedge clk1);
        check_eq("mid_ready1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk1);
        check_eq("mid_mul_a", 32'(mul_a), 0);
        check_eq("mid_mul_b", 32'(mul_b), 0);
        check_eq("mid_res_valid", 32'(res_valid), 0);
        check_eq("mid_res_id", 32'(res_id), 0);
        check_eq("mid_res_data", 32'(res_data), 0);
        check_eq("mid_busy", 32'(busy), 0);
        check_eq("mid_drained", 32'(drained), 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk1);
            check_eq("mid_no_res", 32'(res_valid), 0);
            tick();
        end
        set_op(3, 4'd2, 4'd3);
        req_valid = 4'b1001;
        @(negedge clk1);
        check_eq("mid_ptr_reset", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_empty(20);

        // Requesters 1 and 3 held valid
        do_reset();
        set_op(1, 4'd4, 4'd4);
        set_op(3, 4'd6, 4'd7);
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            exp_r = 4'b0010;
`else
            exp_r = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            @(negedge clk1);
            check_eq("pair_ready", 32'(req_ready), 32'(exp_r));
            tick();
        end
        req_valid = '0;
        wait_empty(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
